timestamp_unit: RTL and testbench

TIMESTAMP_UNIT -- requirements
Module: timestamp_unit

---
 rtl/timestamp_unit.sv | 139 +++++++++++++
 tb/tb_timestamp_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timestamp_unit.sv
`default_nettype none
// ============================================================================
//  Module      : timestamp_unit
//  Description : Free-running timestamp counter with prescaler, wrap epoch
//                counter and per-channel trigger time capture with a
//                valid/ready handshake and sticky overrun flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module timestamp_unit #(
    parameter int TIME_STAMP_WIDTH = 16,
    parameter int DIVIDE_NUM       = 5,
    parameter int N_CH             = 4,
    parameter int EPOCH_WIDTH      = 8
) (
    input  logic                             AXIS_ACLK,
    input  logic                             AXIS_ARESET,
    input  logic [1:0]                       EXEC_STATE,
    input  logic [N_CH-1:0]                  TRIG,
    output logic [TIME_STAMP_WIDTH-1:0]      O_CURRENT_TIME,
    output logic [EPOCH_WIDTH-1:0]           O_EPOCH,
    output logic                             O_TICK,
    output logic [N_CH*TIME_STAMP_WIDTH-1:0] CAP_TIME,
    output logic [N_CH-1:0]                  CAP_VALID,
    input  logic [N_CH-1:0]                  CAP_READY,
    output logic [N_CH-1:0]                  CAP_OVERRUN
);

    localparam int                          c_PS_W     = (DIVIDE_NUM > 1) ? $clog2(DIVIDE_NUM) : 1;
    localparam logic [c_PS_W-1:0]           c_PS_LAST  = c_PS_W'(DIVIDE_NUM - 1);
    localparam logic [TIME_STAMP_WIDTH-1:0] c_TIME_ONE = TIME_STAMP_WIDTH'(1);
    localparam logic [TIME_STAMP_WIDTH-1:0] c_TIME_MAX = '1;
    localparam logic [1:0]                  c_ST_INIT  = 2'b00;

    logic                        r_exec_run;
    logic                        r_time_en;
    logic [c_PS_W-1:0]           r_prescale;
    logic [TIME_STAMP_WIDTH-1:0] r_cur_time;
    logic [EPOCH_WIDTH-1:0]      r_epoch;
    logic                        r_tick;
    logic [N_CH-1:0]             r_trig_q;
    logic                        w_tick;
    logic [N_CH-1:0]             w_rise;

    assign w_tick = r_time_en && (r_prescale == c_PS_LAST);
    assign w_rise = TRIG & ~r_trig_q & {N_CH{r_time_en}};

    // Sample the run state, then register the enable one cycle later
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            r_exec_run <= 1'b0;
            r_time_en  <= 1'b0;
        end else begin
            r_exec_run <= (EXEC_STATE != c_ST_INIT);
            r_time_en  <= r_exec_run;
        end
    end

    // Prescaler: counts 0..DIVIDE_NUM-1 while enabled, parked at 0 otherwise
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET || !r_time_en || w_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

    // Timestamp and epoch; the time skips 0 on wrap since 0 means "no time"
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET || !r_time_en) begin
            r_cur_time <= c_TIME_ONE;
            r_epoch    <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick <= w_tick;
            if (w_tick) begin
                if (r_cur_time == c_TIME_MAX) begin
                    r_cur_time <= c_TIME_ONE;
                    r_epoch    <= r_epoch + 1'b1;
                end else begin
                    r_cur_time <= r_cur_time + 1'b1;
                end
            end
        end
    end

    // Trigger history for rising-edge detection
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            r_trig_q <= '0;
        end else begin
            r_trig_q <= TRIG;
        end
    end

    assign O_CURRENT_TIME = r_cur_time;
    assign O_EPOCH        = r_epoch;
    assign O_TICK         = r_tick;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [TIME_STAMP_WIDTH-1:0] r_cap_time;
            logic                        r_cap_valid;
            logic                        r_cap_ovr;
            logic                        w_xfer;

            assign w_xfer = r_cap_valid & CAP_READY[gi];

            // Capture slot: an edge refills it if empty or draining this
            // cycle, otherwise it is dropped and flagged as an overrun
            always_ff @(posedge AXIS_ACLK) begin
                if (AXIS_ARESET) begin
                    r_cap_time  <= '0;
                    r_cap_valid <= 1'b0;
                    r_cap_ovr   <= 1'b0;
                end else begin
                    if (w_rise[gi]) begin
                        if (!r_cap_valid || w_xfer) begin
                            r_cap_time  <= r_cur_time;
                            r_cap_valid <= 1'b1;
                        end else begin
                            r_cap_ovr <= 1'b1;
                        end
                    end else if (w_xfer) begin
                        r_cap_valid <= 1'b0;
                    end
                    if (!r_time_en) begin
                        r_cap_ovr <= 1'b0;
                    end
                end
            end

            assign CAP_TIME[gi*TIME_STAMP_WIDTH +: TIME_STAMP_WIDTH] = r_cap_time;
            assign CAP_VALID[gi]                                    = r_cap_valid;
            assign CAP_OVERRUN[gi]                                  = r_cap_ovr;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_timestamp_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timestamp_unit
//  Description : Directed self-checking bench for timestamp_unit (W=4, N_CH=2,
//                one instance with DIVIDE_NUM=5 and one with DIVIDE_NUM=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timestamp_unit;

    localparam int c_W  = 4;
    localparam int c_NC = 2;
    localparam int c_EW = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          exec_state;
    logic [c_NC-1:0]     trig;
    logic [c_NC-1:0]     cap_ready;

    logic [c_W-1:0]      cur;
    logic [c_EW-1:0]     epoch;
    logic                tick;
    logic [c_NC*c_W-1:0] cap_time;
    logic [c_NC-1:0]     cap_valid;
    logic [c_NC-1:0]     cap_ovr;

    logic [c_W-1:0]      cur1;
    logic [c_EW-1:0]     epoch1;
    logic                tick1;
    logic [c_NC*c_W-1:0] cap_time1;
    logic [c_NC-1:0]     cap_valid1;
    logic [c_NC-1:0]     cap_ovr1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    timestamp_unit #(
        .TIME_STAMP_WIDTH (c_W),
        .DIVIDE_NUM       (5),
        .N_CH             (c_NC),
        .EPOCH_WIDTH      (c_EW)
    ) u_dut (
        .AXIS_ACLK      (clk),
        .AXIS_ARESET    (rst),
        .EXEC_STATE     (exec_state),
        .TRIG           (trig),
        .O_CURRENT_TIME (cur),
        .O_EPOCH        (epoch),
        .O_TICK         (tick),
        .CAP_TIME       (cap_time),
        .CAP_VALID      (cap_valid),
        .CAP_READY      (cap_ready),
        .CAP_OVERRUN    (cap_ovr)
    );

    timestamp_unit #(
        .TIME_STAMP_WIDTH (c_W),
        .DIVIDE_NUM       (1),
        .N_CH             (c_NC),
        .EPOCH_WIDTH      (c_EW)
    ) u_dut_div1 (
        .AXIS_ACLK      (clk),
        .AXIS_ARESET    (rst),
        .EXEC_STATE     (exec_state),
        .TRIG           (trig),
        .O_CURRENT_TIME (cur1),
        .O_EPOCH        (epoch1),
        .O_TICK         (tick1),
        .CAP_TIME       (cap_time1),
        .CAP_VALID      (cap_valid1),
        .CAP_READY      (cap_ready),
        .CAP_OVERRUN    (cap_ovr1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance until the current time reads target, bounded by limit cycles
    task automatic wait_for(input logic [c_W-1:0] target, input int limit);
        int n = 0;
        step();
        while (cur !== target && n < limit) begin
            step();
            n++;
        end
        check("wait_time", 32'(cur), 32'(target));
    endtask

    initial begin
        rst        = 1'b1;
        exec_state = 2'b00;
        trig       = '0;
        cap_ready  = '0;
        repeat (3) step();

        // Reset values
        check("rst_time",    32'(cur),       32'd1);
        check("rst_epoch",   32'(epoch),     32'd0);
        check("rst_tick",    32'(tick),      32'd0);
        check("rst_valid",   32'(cap_valid), 32'd0);
        check("rst_captime", 32'(cap_time),  32'd0);
        check("rst_ovr",     32'(cap_ovr),   32'd0);

        rst = 1'b0;
        step();
        check("idle_time", 32'(cur), 32'd1);

        // Start: EXEC_STATE sampled at E0
        exec_state = 2'b11;
        step();                                   // E0
        step();                                   // E0+1
        step();                                   // E0+2
        check("div1_first_time", 32'(cur1),  32'd2);
        check("div1_first_tick", 32'(tick1), 32'd1);
        step();                                   // E0+3
        check("div1_second_time", 32'(cur1),  32'd3);
        check("div1_second_tick", 32'(tick1), 32'd1);
        step();                                   // E0+4
        step();                                   // E0+5
        check("pre_tick_time", 32'(cur),  32'd1);
        check("pre_tick_tick", 32'(tick), 32'd0);
        step();                                   // E0+6
        check("first_tick_time", 32'(cur),  32'd2);
        check("first_tick_tick", 32'(tick), 32'd1);
        step();                                   // E0+7
        check("tick_one_cycle", 32'(tick), 32'd0);
        repeat (3) step();                        // E0+10
        check("before_second_tick", 32'(cur), 32'd2);
        step();                                   // E0+11
        check("second_tick_time", 32'(cur),  32'd3);
        check("second_tick_tick", 32'(tick), 32'd1);

        // Capture at 7, overrun at 9
        wait_for(4'd7, 100);
        trig[0] = 1'b1;
        step();
        check("cap0_valid",   32'(cap_valid[0]),  32'd1);
        check("cap0_time",    32'(cap_time[3:0]), 32'd7);
        check("cap0_ovr_clr", 32'(cap_ovr[0]),    32'd0);
        trig[0] = 1'b0;
        wait_for(4'd9, 100);
        trig[0] = 1'b1;
        step();
        check("ovr0_time",  32'(cap_time[3:0]), 32'd7);
        check("ovr0_flag",  32'(cap_ovr[0]),    32'd1);
        check("ovr0_valid", 32'(cap_valid[0]),  32'd1);
        trig[0]      = 1'b0;
        cap_ready[0] = 1'b1;
        step();
        cap_ready[0] = 1'b0;
        check("xfer0_valid",  32'(cap_valid[0]),  32'd0);
        check("ovr0_sticky",  32'(cap_ovr[0]),    32'd1);
        check("ch1_valid",    32'(cap_valid[1]),  32'd0);
        check("ch1_ovr",      32'(cap_ovr[1]),    32'd0);
        check("ch1_time",     32'(cap_time[7:4]), 32'd0);

        // Wrap 15 -> 1 with epoch increment
        wait_for(4'd15, 100);
        check("pre_wrap_epoch", 32'(epoch), 32'd0);
        wait_for(4'd1, 20);
        check("wrap_epoch", 32'(epoch), 32'd1);
        check("wrap_tick",  32'(tick),  32'd1);

        // Transfer and new edge in the same cycle on channel 1
        wait_for(4'd3, 40);
        trig[1] = 1'b1;
        step();
        check("cap1_time3", 32'(cap_time[7:4]), 32'd3);
        check("cap1_valid", 32'(cap_valid[1]),  32'd1);
        trig[1] = 1'b0;
        wait_for(4'd4, 20);                       // U: time just became 4
        trig[1]      = 1'b1;
        cap_ready[1] = 1'b1;
        step();                                   // U+1
        check("simul_valid", 32'(cap_valid[1]),  32'd1);
        check("simul_time",  32'(cap_time[7:4]), 32'd4);
        check("simul_ovr",   32'(cap_ovr[1]),    32'd0);
        trig[1] = 1'b0;
        step();                                   // U+2: drain
        cap_ready[1] = 1'b0;
        check("drain1_valid", 32'(cap_valid[1]), 32'd0);
        step();                                   // U+3
        step();                                   // U+4
        trig[1] = 1'b1;
        step();                                   // U+5: tick and edge together
        check("coinc_time_now", 32'(cur),           32'd5);
        check("coinc_tick",     32'(tick),          32'd1);
        check("coinc_cap_pre",  32'(cap_time[7:4]), 32'd4);
        check("coinc_valid",    32'(cap_valid[1]),  32'd1);
        trig[1] = 1'b0;
        check("ch0_ovr_kept", 32'(cap_ovr[0]), 32'd1);

        // Stop: time returns to 1, epoch to 0, overrun cleared
        exec_state = 2'b00;
        step();
        step();
        step();
        check("stop_time",     32'(cur),        32'd1);
        check("stop_epoch",    32'(epoch),      32'd0);
        check("stop_tick",     32'(tick),       32'd0);
        check("stop_ovr_clr",  32'(cap_ovr[0]), 32'd0);
        check("stop_div1",     32'(cur1),       32'd1);
        trig[0] = 1'b1;
        step();
        check("stop_edge_ign", 32'(cap_valid[0]),  32'd0);
        check("stop_keep_vld", 32'(cap_valid[1]),  32'd1);
        check("stop_keep_tim", 32'(cap_time[7:4]), 32'd4);
        trig[0] = 1'b0;

        // Reset pulse coincident with a tick
        exec_state = 2'b01;
        wait_for(4'd2, 40);                       // U: first tick after restart
        repeat (4) step();                        // U+4
        check("pre_rst_time", 32'(cur), 32'd2);
        rst = 1'b1;
        step();                                   // U+5: tick suppressed by reset
        check("mid_rst_time",   32'(cur),       32'd1);
        check("mid_rst_epoch",  32'(epoch),     32'd0);
        check("mid_rst_tick",   32'(tick),      32'd0);
        check("mid_rst_valid",  32'(cap_valid), 32'd0);
        check("mid_rst_cap",    32'(cap_time),  32'd0);
        check("mid_rst_ovr",    32'(cap_ovr),   32'd0);
        check("mid_rst_div1",   32'(cur1),      32'd1);
        rst        = 1'b0;
        exec_state = 2'b00;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
